nn_f0_conv_ctrl: RTL

Sequencer for the first conv layer of the nn_f0 network: latches a 12×12 map of 2-bit pixels and a bank of four 3×3 2-bit filters on `start`. It then steps one shared 3×3 multiply-accumulate through every (filter, row, col) window and streams out one valid-only 10×10 result per filter over a valid/ready port. It sits between the map/filter loader and the pooling/activation stage, and replaces a fully parallel conv array with a time-multiplexed one.

---
 rtl/nn_f0_pkg.sv | 30 +++
 rtl/nn_f0_conv_ctrl_if.sv | 14 +
 rtl/nn_f0_mac3x3.sv | 19 +
 rtl/nn_f0_conv_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/nn_f0_pkg.sv
// Shared sizes, FSM encoding and bit-index helpers for the nn_f0 first conv layer.
package nn_f0_pkg;

  localparam int IMG_W = 12;
  localparam int K     = 3;
  localparam int NFILT = 4;
  localparam int PIX_W = 2;
  localparam int ACC_W = 8;

  localparam int OUT_W  = IMG_W - K + 1;
  localparam int WIN_W  = K * K * PIX_W;
  localparam int MAP_W  = IMG_W * IMG_W * PIX_W;
  localparam int BANK_W = NFILT * WIN_W;

  localparam int FILT_BITS  = $clog2(NFILT);
  localparam int COORD_BITS = $clog2(OUT_W);
  localparam int MAP_IDX_W  = $clog2(MAP_W);
  localparam int BANK_IDX_W = $clog2(BANK_W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int pix_idx(int r, int c);
    return PIX_W * (IMG_W * r + c);
  endfunction

  function automatic int tap_idx(int i, int j);
    return PIX_W * (K * i + j);
  endfunction

endpackage

// File: rtl/nn_f0_conv_ctrl_if.sv
// Result stream from the conv sequencer to the pooling/activation stage.
interface nn_f0_conv_ctrl_if;
  import nn_f0_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [FILT_BITS-1:0]  out_filt;
  logic [COORD_BITS-1:0] out_row;
  logic [COORD_BITS-1:0] out_col;
  logic [ACC_W-1:0]      out_pix;

  modport master (output out_valid, out_filt, out_row, out_col, out_pix, input out_ready);
  modport slave  (input out_valid, out_filt, out_row, out_col, out_pix, output out_ready);
endinterface

// File: rtl/nn_f0_mac3x3.sv
// Combinational 3x3 unsigned multiply-accumulate over one window and one filter.
module nn_f0_mac3x3 import nn_f0_pkg::*; (
  input  logic [WIN_W-1:0] win,
  input  logic [WIN_W-1:0] wts,
  output logic [ACC_W-1:0] sum
);

  logic [2*PIX_W-1:0] prod [K*K];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum = '0;
    for (int t = 0; t < K*K; t++) begin
      prod[t] = (2*PIX_W)'(win[t*PIX_W +: PIX_W]) * (2*PIX_W)'(wts[t*PIX_W +: PIX_W]);
      sum     = sum + ACC_W'(prod[t]);
    end
  end

endmodule

// File: rtl/nn_f0_conv_ctrl.sv
// Time-multiplexed conv sequencer: latches map and filters, scans every
// (filter,row,col) window through one shared MAC and streams results out.
module nn_f0_conv_ctrl import nn_f0_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAP_W-1:0]   in_map,
  input  logic [BANK_W-1:0]  filter_bank,
  output logic               busy,
  output logic               done,
  nn_f0_conv_ctrl_if.master  res
);

  localparam logic [FILT_BITS-1:0]  LAST_FILT  = FILT_BITS'(NFILT - 1);
  localparam logic [COORD_BITS-1:0] LAST_COORD = COORD_BITS'(OUT_W - 1);

  state_t state_q, state_d;

  logic [MAP_W-1:0]      map_q;
  logic [BANK_W-1:0]     bank_q;
  logic [FILT_BITS-1:0]  filt_q;
  logic [COORD_BITS-1:0] row_q, col_q;

  logic                  valid_q;
  logic [FILT_BITS-1:0]  ofilt_q;
  logic [COORD_BITS-1:0] orow_q, ocol_q;
  logic [ACC_W-1:0]      opix_q;

  logic             load, issue, accept, last_win;
  logic [WIN_W-1:0] win, wts;
  logic [ACC_W-1:0] mac_sum;

  assign accept   = valid_q && res.out_ready;
  assign last_win = (filt_q == LAST_FILT) && (row_q == LAST_COORD) && (col_q == LAST_COORD);

  always_comb begin
    win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win[tap_idx(i, j) +: PIX_W] =
          map_q[MAP_IDX_W'(pix_idx(int'(row_q) + i, int'(col_q) + j)) +: PIX_W];
      end
    end
  end

  assign wts = bank_q[BANK_IDX_W'(int'(filt_q) * WIN_W) +: WIN_W];

  nn_f0_mac3x3 u_mac (
    .win (win),
    .wts (wts),
    .sum (mac_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) begin
               state_d = RUN;
               load    = 1'b1;
             end
      RUN: begin
        busy = 1'b1;
        // A window issues only into an empty register or one draining this cycle.
        if (!valid_q || res.out_ready) begin
          issue = 1'b1;
          if (last_win) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (accept) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the latched map/filter registers are reset too, so no X ever reaches the MAC or outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q   <= '0;
      bank_q  <= '0;
      filt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      ofilt_q <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      opix_q  <= '0;
    end else begin
      if (load) begin
        map_q  <= in_map;
        bank_q <= filter_bank;
        filt_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
      end
      if (issue) begin
        valid_q <= 1'b1;
        ofilt_q <= filt_q;
        orow_q  <= row_q;
        ocol_q  <= col_q;
        opix_q  <= mac_sum;
        if (col_q == LAST_COORD) begin
          col_q <= '0;
          if (row_q == LAST_COORD) begin
            row_q  <= '0;
            filt_q <= filt_q + FILT_BITS'(1);
          end else begin
            row_q <= row_q + COORD_BITS'(1);
          end
        end else begin
          col_q <= col_q + COORD_BITS'(1);
        end
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign res.out_valid = valid_q;
  assign res.out_filt  = ofilt_q;
  assign res.out_row   = orow_q;
  assign res.out_col   = ocol_q;
  assign res.out_pix   = opix_q;

endmodule
